// File: rtl/cache_refill_unit.sv
// Line-refill engine: turns one cache line miss into a single AXI INCR read burst
// and returns the assembled line, its aligned address and an error flag.
module cache_refill_unit #(
  parameter int unsigned LINE_WIDTH     = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [ADDR_WIDTH-1:0]     ar_addr_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  output logic [ID_WIDTH-1:0]       ar_id_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [LINE_WIDTH-1:0]     resp_line_o,
  output logic [ADDR_WIDTH-1:0]     resp_addr_o,
  output logic                      resp_err_o
);

  localparam int unsigned BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned OFF   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  if ((LINE_WIDTH % AXI_DATA_WIDTH) != 0 || BEATS < 1 || BEATS > 256 ||
      (BEATS & (BEATS - 1)) != 0) begin : g_param_check
    $error("cache_refill_unit: LINE_WIDTH/AXI_DATA_WIDTH must be a power of two in 1..256");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                  state_q;
  logic                    req_ready_q;
  logic                    ar_valid_q;
  logic                    r_ready_q;
  logic                    resp_valid_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      addr_q       <= '0;
      line_q       <= '0;
      beat_cnt     <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q      <= req_addr_i & ~OFF_MASK;
            beat_cnt    <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            ar_valid_q  <= 1'b1;
            state_q     <= ADDR;
          end
        end
        ADDR: begin
          if (ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (r_valid_i) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
              if (beat_cnt == CNT_W'(b)) begin
                line_q[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= r_data_i;
              end
            end
            beat_cnt <= beat_cnt + CNT_W'(1);
            // A misplaced (or missing) r_last only flags the line; the beat count ends the burst.
            if (r_resp_i != 2'b00 || r_last_i != (beat_cnt == LAST_BEAT)) begin
              err_q <= 1'b1;
            end
            if (beat_cnt == LAST_BEAT) begin
              r_ready_q    <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign ar_valid_o   = ar_valid_q;
  assign ar_addr_o    = addr_q;
  assign ar_len_o     = 8'(BEATS - 1);
  assign ar_size_o    = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign ar_burst_o   = 2'b01;
  assign ar_id_o      = ID_WIDTH'(AXI_ID);
  assign r_ready_o    = r_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_line_o  = line_q;
  assign resp_addr_o  = addr_q;
  assign resp_err_o   = err_q;

endmodule
